dag_cb: RTL
===========

# dag_cb

Parametrised multi-channel circular-buffer data address generator for the FIR datapath. It holds NCH independently configured circular buffers. Each request on a channel issues that channel's current pointer, registered, and advances the pointer by a signed power-of-two stride. Wrap-around is true modulo (buffer length is preserved across the boundary), not a snap to base/top. Unlike the first-generation DAG, it drives a valid strobe instead of a high-Z bus, and adds a wrap flag, an error flag, a per-channel rewind and an explicit reset.

## Interface
- AW, 16, address width
- LW, 12, buffer length width
- NCH, 8, number of channels (power of two, ≥2)
- EW, 3, stride exponent width; stride = 2^cfg_expt
- CW = $clog2(NCH), derived channel-select width
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- cfg_we  in  1  write config to channel cfg_ch
- cfg_rewind  in  1  reset pointer of cfg_ch to its base, config kept
- cfg_ch  in  CW  config channel select
- cfg_base  in  AW  buffer base address
- cfg_len  in  LW  buffer length L; valid addresses base..base+L-1
- cfg_sign  in  1  0 = increment, 1 = decrement
- cfg_expt  in  EW  stride exponent
- req  in  1  address request
- req_ch  in  CW  request channel select
- addr  out  AW  issued address
- addr_vld  out  1  addr valid, one-cycle pulse per accepted request
- wrap  out  1  qualified by addr_vld: this issue caused the pointer to wrap
- err  out  1  one-cycle pulse: rejected config or rejected request

## Operation
- Per-channel state: base, top = base+L (AW+1 bits), signed stride (AW+1 bits), ptr, cfg_ok.
- Config accept (cfg_we=1): requires L≠0, 2^expt ≤ L, and base+L ≤ 2^AW.
  - On accept: base/top/stride are loaded, ptr←base, cfg_ok←1.
  - On reject: the channel is unchanged and err=1 on the next cycle.
- Rewind (cfg_rewind=1, cfg_we=0): ptr←base if cfg_ok, else err. cfg_we has priority over cfg_rewind.
- Request (req=1) on channel c with cfg_ok:
  - addr←ptr and addr_vld←1.
  - nxt = ptr ± stride, computed in AW+1 bits.
  - If nxt ≥ top: ptr←nxt−L and wrap←1.
  - Else if nxt < base: ptr←nxt+L and wrap←1.
  - Otherwise ptr←nxt and wrap←0.
- Request on an unconfigured channel: addr_vld=0, err=1, addr holds its previous value.
- Collision: if cfg_we or cfg_rewind targets the same channel as req in the same cycle, the config action wins and the request is dropped (addr_vld=0, err=1).
- If the config action and the request target different channels, both proceed.
- Only one err pulse is produced per cycle; the causes are ORed.
- Back-to-back requests on the same channel issue successive addresses every cycle with no bubble.

## Timing
- Reset (rst_n=0 at an edge): all cfg_ok←0, ptr←0, addr←0, addr_vld←0, wrap←0, err←0. Reset mid-stream discards in-flight state; the first edge with rst_n=1 may accept cfg_we.
- Request latency: req sampled at edge N; addr, addr_vld and wrap are valid after edge N and stay valid for one cycle.
- Config latency: config written at edge N may be requested at edge N+1. That request returns base.
- err asserts after the edge that sampled the faulting action and lasts one cycle.
- When addr_vld=0, wrap=0. addr holds its last value and is never Z.
- Throughput is one request per cycle in total across all channels.

## Test plan
- Forward wrap: cfg ch0 base=0x100, L=5, expt=1, sign=0, then 6 reqs → addr 0x100, 0x102, 0x104(wrap), 0x101, 0x103(wrap), 0x100.
- Reverse wrap: same channel reconfigured with sign=1, then 6 reqs → 0x100(wrap), 0x103, 0x101(wrap), 0x104, 0x102, 0x100(wrap).
- Rejects:
  - Request on unconfigured ch3 after reset → err=1, addr_vld=0.
  - cfg L=2, expt=2 → err=1; the channel's previous behaviour is unchanged.
  - cfg base=0xFFFE, L=4 → err=1.
- Collision: ch1 streaming; cfg_we on ch1 and req on ch1 in the same cycle → err=1, no addr_vld; the next req returns the new base. cfg_we on ch2 with req on ch1 → ch1 addr issued, ch2 loaded.
- Rewind: ch0 ptr at 0x103, cfg_rewind ch0 → next req returns 0x100.
- Reset mid-stream: rst_n=0 for one edge during streaming → all outputs 0; a subsequent req on ch0 → err=1.

Source files
------------

// File: rtl/dag_cb_if.sv
// Config/request/issue bundle for the circular-buffer address generator.
// master drives config and requests; slave is the generator.
interface dag_cb_if #(
   parameter int AW  = 16,
   parameter int LW  = 12,
   parameter int NCH = 8,
   parameter int EW  = 3
);
   localparam int CW = $clog2(NCH);

   logic          cfg_we;
   logic          cfg_rewind;
   logic [CW-1:0] cfg_ch;
   logic [AW-1:0] cfg_base;
   logic [LW-1:0] cfg_len;
   logic          cfg_sign;
   logic [EW-1:0] cfg_expt;
   logic          req;
   logic [CW-1:0] req_ch;
   logic [AW-1:0] addr;
   logic          addr_vld;
   logic          wrap;
   logic          err;

   modport master (
      output cfg_we, cfg_rewind, cfg_ch, cfg_base, cfg_len, cfg_sign, cfg_expt,
      output req, req_ch,
      input  addr, addr_vld, wrap, err
   );

   modport slave (
      input  cfg_we, cfg_rewind, cfg_ch, cfg_base, cfg_len, cfg_sign, cfg_expt,
      input  req, req_ch,
      output addr, addr_vld, wrap, err
   );
endinterface

// File: rtl/dag_cb.sv
// Multi-channel circular-buffer address generator: per-channel pointer
// state lives in dag_cb_ch, the top decodes config/request and registers the issue.
module dag_cb_ch #(
   parameter int AW = 16,
   parameter int LW = 12,
   parameter int EW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ld,
   input  logic          rw,
   input  logic          adv,
   input  logic [AW-1:0] base_in,
   input  logic [LW-1:0] len_in,
   input  logic          neg_in,
   input  logic [EW-1:0] expt_in,
   output logic [AW-1:0] ptr,
   output logic          ok,
   output logic          wrap_nxt
);
   logic [AW-1:0] base;
   logic [AW:0]   top;
   logic [AW:0]   step;
   logic          neg;
   logic [AW:0]   ptr_x, len_x, nxt, nxt_fix;

   // Stride never exceeds the length, so one +/-L correction restores range.
   // Decrement wrap is tested before subtracting so an underflow below 0
   // cannot masquerade as an overshoot past top.
   always_comb begin
      ptr_x   = {1'b0, ptr};
      len_x   = top - {1'b0, base};
      nxt     = neg ? (ptr_x - step) : (ptr_x + step);
      nxt_fix = nxt;
      wrap_nxt = 1'b0;
      if (neg) begin
         wrap_nxt = ptr_x < ({1'b0, base} + step);
         if (wrap_nxt) nxt_fix = nxt + len_x;
      end else begin
         wrap_nxt = nxt >= top;
         if (wrap_nxt) nxt_fix = nxt - len_x;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         base <= '0;
         top  <= '0;
         step <= '0;
         neg  <= 1'b0;
         ptr  <= '0;
         ok   <= 1'b0;
      end else if (ld) begin
         base <= base_in;
         top  <= {1'b0, base_in} + (AW+1)'(len_in);
         step <= (AW+1)'(1) << expt_in;
         neg  <= neg_in;
         ptr  <= base_in;
         ok   <= 1'b1;
      end else if (rw && ok) begin
         ptr <= base;
      end else if (adv) begin
         ptr <= nxt_fix[AW-1:0];
      end
   end
endmodule

module dag_cb #(
   parameter int AW  = 16,
   parameter int LW  = 12,
   parameter int NCH = 8,
   parameter int EW  = 3
) (
   input logic     clk,
   input logic     rst_n,
   dag_cb_if.slave bus
);
   localparam int CW = $clog2(NCH);

   logic [NCH-1:0][AW-1:0] ptr;
   logic [NCH-1:0]         ok, wr, ld, rw, adv;
   logic [AW:0]            pow, len_x, end_x;
   logic                   cfg_good, cfg_act, collide, req_ok, err_nxt;

   always_comb begin
      pow      = (AW+1)'(1) << bus.cfg_expt;
      len_x    = (AW+1)'(bus.cfg_len);
      end_x    = {1'b0, bus.cfg_base} + len_x;
      cfg_good = (bus.cfg_len != '0) && (pow <= len_x) &&
                 (end_x <= {1'b1, {AW{1'b0}}});
      cfg_act  = bus.cfg_we | bus.cfg_rewind;
      // A config action on the requested channel wins; the request is dropped.
      collide  = cfg_act & bus.req & (bus.cfg_ch == bus.req_ch);
      req_ok   = bus.req & ok[bus.req_ch] & ~collide;
      err_nxt  = (bus.cfg_we & ~cfg_good) |
                 (~bus.cfg_we & bus.cfg_rewind & ~ok[bus.cfg_ch]) |
                 (bus.req & ~req_ok);
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      assign ld[c]  = bus.cfg_we & cfg_good & (bus.cfg_ch == CW'(c));
      assign rw[c]  = ~bus.cfg_we & bus.cfg_rewind & (bus.cfg_ch == CW'(c));
      assign adv[c] = req_ok & (bus.req_ch == CW'(c));

      dag_cb_ch #(.AW(AW), .LW(LW), .EW(EW)) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .ld       (ld[c]),
         .rw       (rw[c]),
         .adv      (adv[c]),
         .base_in  (bus.cfg_base),
         .len_in   (bus.cfg_len),
         .neg_in   (bus.cfg_sign),
         .expt_in  (bus.cfg_expt),
         .ptr      (ptr[c]),
         .ok       (ok[c]),
         .wrap_nxt (wr[c])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.addr     <= '0;
         bus.addr_vld <= 1'b0;
         bus.wrap     <= 1'b0;
         bus.err      <= 1'b0;
      end else begin
         bus.addr_vld <= req_ok;
         bus.wrap     <= req_ok & wr[bus.req_ch];
         bus.err      <= err_nxt;
         if (req_ok) bus.addr <= ptr[bus.req_ch];
      end
   end
endmodule
